// File: rtl/hash_function.sv
// hash_function: iterative 32-bit hash core.
// Compresses a 4-byte message into a 4-byte digest chained from a 4-byte IV,
// one mixing round per clock. Each message byte is mixed for ROUNDS rounds,
// so one hash takes 4*ROUNDS cycles in RUN after the capture edge.
// Optional build macro: HASH_FEEDFORWARD_EN (XOR the captured IV into the
// final state to form the digest; otherwise the raw final state is output).
module hash_function #(
  parameter int unsigned ROUNDS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] m   [0:3],
  input  logic [7:0] IV  [0:3],
  output logic [7:0] d   [0:3],
  output logic       done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // One mixing round; bytes are packed with H0 in the top byte.
  function automatic logic [31:0] mix_round(input logic [31:0] h,
                                            input logic [7:0]  b,
                                            input logic [7:0]  r);
    logic [7:0] x0, x1, x2, x3;
    logic [7:0] n0, n1, n2, n3;
    x0 = h[31:24] ^ b;
    x1 = h[23:16] ^ b;
    x2 = h[15:8]  ^ b;
    x3 = h[7:0]   ^ b;
    n0 = {x3[6:0], x3[7]}   + x0;
    n1 = {x0[5:0], x0[7:6]} ^ x1;
    n2 = {x1[4:0], x1[7:5]} + x2;
    n3 = {x2[2:0], x2[7:3]} ^ x3 ^ r;
    return {n0, n1, n2, n3};
  endfunction

  // Final digest formation from the last state and the captured IV.
  function automatic logic [31:0] finalize(input logic [31:0] h,
                                           input logic [31:0] iv);
`ifdef HASH_FEEDFORWARD_EN
    return h ^ iv;
`else
    return h ^ (iv & 32'h0000_0000);
`endif
  endfunction

  state_e      state_q, state_d;
  logic [31:0] h_q, h_d;
  logic [31:0] m_lat_q, m_lat_d;
  logic [31:0] iv_lat_q, iv_lat_d;
  logic [5:0]  rnd_q, rnd_d;       // round index within the current byte
  logic [1:0]  byte_q, byte_d;     // which message byte is being mixed
  logic [31:0] dig_q, dig_d;
  logic        done_q, done_d;

  logic [7:0]  cur_byte;
  logic        last_rnd;
  logic        last_op;

  // Select the message byte currently being mixed (m[0] first).
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      2'd0:    cur_byte = m_lat_q[31:24];
      2'd1:    cur_byte = m_lat_q[23:16];
      2'd2:    cur_byte = m_lat_q[15:8];
      2'd3:    cur_byte = m_lat_q[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  assign last_rnd = (rnd_q == 6'(ROUNDS - 1));
  assign last_op  = last_rnd && (byte_q == 2'd3);

  // Next-state and datapath: capture in IDLE, one round per edge in RUN.
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    m_lat_d  = m_lat_q;
    iv_lat_d = iv_lat_q;
    rnd_d    = rnd_q;
    byte_d   = byte_q;
    dig_d    = dig_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          h_d      = {IV[0], IV[1], IV[2], IV[3]};
          m_lat_d  = {m[0], m[1], m[2], m[3]};
          iv_lat_d = {IV[0], IV[1], IV[2], IV[3]};
          rnd_d    = 6'd0;
          byte_d   = 2'd0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        h_d = mix_round(h_q, cur_byte, {2'b00, rnd_q});
        if (last_op) begin
          dig_d   = finalize(h_d, iv_lat_q);
          done_d  = 1'b1;
          rnd_d   = 6'd0;
          byte_d  = 2'd0;
          state_d = S_IDLE;
        end else if (last_rnd) begin
          rnd_d   = 6'd0;
          byte_d  = byte_q + 2'd1;
        end else begin
          rnd_d   = rnd_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      h_q      <= 32'h0000_0000;
      m_lat_q  <= 32'h0000_0000;
      iv_lat_q <= 32'h0000_0000;
      rnd_q    <= 6'd0;
      byte_q   <= 2'd0;
      dig_q    <= 32'h0000_0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      m_lat_q  <= m_lat_d;
      iv_lat_q <= iv_lat_d;
      rnd_q    <= rnd_d;
      byte_q   <= byte_d;
      dig_q    <= dig_d;
      done_q   <= done_d;
    end
  end

  assign d[0] = dig_q[31:24];
  assign d[1] = dig_q[23:16];
  assign d[2] = dig_q[15:8];
  assign d[3] = dig_q[7:0];
  assign done = done_q;

endmodule

// File: tb/tb_hash_function.sv
// Self-checking bench for hash_function: random and directed vectors checked
// against a behavioural model that follows the HASH_FEEDFORWARD_EN macro.
module tb_hash_function;

  localparam int ROUNDS = 8;
  localparam int LAT    = 4 * ROUNDS;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] m_s  [0:3];
  logic [7:0] iv_s [0:3];
  logic [7:0] d_s  [0:3];
  logic       done_s;

  int checks;
  int errors;

  hash_function #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m     (m_s),
    .IV    (iv_s),
    .d     (d_s),
    .done  (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rotl(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  // Reference model: direct transcription of the round rules on integers.
  function automatic logic [31:0] model(input logic [7:0] mm [0:3],
                                        input logic [7:0] iv [0:3]);
    int h [4];
    int x [4];
    int b, r;
    logic [31:0] res;
    for (int j = 0; j < 4; j++) h[j] = int'(iv[j]);
    for (int k = 0; k < 4 * ROUNDS; k++) begin
      b = int'(mm[k / ROUNDS]);
      r = k % ROUNDS;
      for (int j = 0; j < 4; j++) x[j] = h[j] ^ b;
      h[0] = (rotl(x[3], 1) + x[0]) % 256;
      h[1] = rotl(x[0], 2) ^ x[1];
      h[2] = (rotl(x[1], 3) + x[2]) % 256;
      h[3] = (rotl(x[2], 5) ^ x[3] ^ r) & 255;
    end
`ifdef HASH_FEEDFORWARD_EN
    for (int j = 0; j < 4; j++) h[j] = h[j] ^ int'(iv[j]);
`endif
    res = {h[0][7:0], h[1][7:0], h[2][7:0], h[3][7:0]};
    return res;
  endfunction

  function automatic logic [31:0] dig();
    return {d_s[0], d_s[1], d_s[2], d_s[3]};
  endfunction

  task automatic scramble_inputs();
    for (int j = 0; j < 4; j++) begin
      m_s[j]  = 8'($urandom);
      iv_s[j] = 8'($urandom);
    end
  endtask

  // Present a vector with start high across one edge; returns at a negedge.
  task automatic issue(input logic [7:0] mv [0:3], input logic [7:0] ivv [0:3]);
    m_s   = mv;
    iv_s  = ivv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
  endtask

  // Count edges after capture until done; optional start pulses at p1/p2.
  task automatic wait_done(input int p1, input int p2, output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
      if (done_s) begin
        start = 1'b0;
        lat   = k;
        break;
      end
      start = (k == p1) || (k == p2);
    end
  endtask

  logic [7:0]  m1 [0:3];
  logic [7:0]  m2 [0:3];
  logic [7:0]  iv1 [0:3];
  logic [7:0]  mr [0:3];
  logic [7:0]  ivr [0:3];
  logic [31:0] exp1, exp2, dig1, dig2;
  int          lat;
  int          ndone;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    scramble_inputs();
    m1  = '{8'h01, 8'h02, 8'h03, 8'h04};
    m2  = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
    iv1 = '{8'h34, 8'h55, 8'h0F, 8'h14};
    exp1 = model(m1, iv1);
    exp2 = model(m2, iv1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_d", dig(), 32'h0);
    check_eq("rst_done", {31'h0, done_s}, 32'h0);
    rst_n = 1'b1;

    // Nominal hash
    issue(m1, iv1);
    wait_done(0, 0, lat);
    check_eq("nom_lat", lat, LAT);
    dig1 = dig();
    check_eq("nom_dig", dig1, exp1);
    @(posedge clk);
    @(negedge clk);
    check_eq("nom_done_1cyc", {31'h0, done_s}, 32'h0);
    check_eq("nom_hold", dig(), exp1);

    // Second vector, then repeat the first
    issue(m2, iv1);
    wait_done(0, 0, lat);
    check_eq("v2_lat", lat, LAT);
    dig2 = dig();
    check_eq("v2_dig", dig2, exp2);
    check_eq("v2_differs", {31'h0, dig2 != dig1}, 32'h1);
    issue(m1, iv1);
    wait_done(0, 0, lat);
    check_eq("rep_dig", dig(), exp1);

    // Start pulses during RUN are ignored
    issue(m1, iv1);
    wait_done(5, 20, lat);
    check_eq("ign_lat", lat, LAT);
    check_eq("ign_dig", dig(), exp1);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s) ndone++;
    end
    check_eq("ign_no_extra", ndone, 0);

    // Back-to-back: start in the done cycle, inputs changed after capture
    issue(m2, iv1);
    wait_done(0, 0, lat);
    check_eq("b2b_first", dig(), exp2);
    issue(m1, iv1);
    wait_done(0, 0, lat);
    check_eq("b2b_gap", lat + 1, LAT + 1);
    check_eq("b2b_dig", dig(), exp1);

    // Random vectors, some back-to-back
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 4; j++) begin
        mr[j]  = 8'($urandom);
        ivr[j] = 8'($urandom);
      end
      issue(mr, ivr);
      wait_done(int'($urandom_range(1, 31)), 0, lat);
      check_eq("rnd_lat", lat, LAT);
      check_eq("rnd_dig", dig(), model(mr, ivr));
      if (t[0]) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Reset mid-RUN clears outputs asynchronously and aborts the hash
    issue(m2, iv1);
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_d", dig(), 32'h0);
    check_eq("mid_rst_done", {31'h0, done_s}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_s) ndone++;
    end
    check_eq("mid_rst_nodone", ndone, 0);
    check_eq("mid_rst_d_held", dig(), 32'h0);
    issue(m1, iv1);
    wait_done(0, 0, lat);
    check_eq("post_rst_lat", lat, LAT);
    check_eq("post_rst_dig", dig(), exp1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/hash_function.md
# hash_function

Lightweight iterative 32-bit hash core: compresses a 4-byte message into a 4-byte digest, chained from a 4-byte initial value (IV). One mixing round per clock; a `start`/`done` handshake frames each operation. Used as a standalone hash primitive in the security datapath: integrity tags and key derivation.

## Interface
- `ROUNDS`, default 8: rounds applied per message byte; legal range 1..63.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a hash; sampled only in IDLE.
- `m` input, unpacked `[0:3]` of 8 bits: message bytes; `m[0]` is processed first.
- `IV` input, unpacked `[0:3]` of 8 bits: chaining/initial value.
- `d` output, unpacked `[0:3]` of 8 bits: digest; registered, holds until the next completion.
- `done` output, 1 bit: one-cycle pulse marking `d` valid.

## Operation
- States: IDLE, RUN.
- IDLE with `start`=1 at a clock edge:
  - load state `H[j]=IV[j]`;
  - latch `m` and `IV` into internal registers;
  - clear counter `cnt`;
  - go to RUN.
- Inputs may change after the capture edge.
- RUN, each edge, applies one round with byte `b=m_lat[cnt/ROUNDS]` and round index `r=cnt%ROUNDS` (8-bit). Then `cnt++`.
- Round, with `x[j]=H[j]^b`, all arithmetic mod 256, `rotl` an 8-bit rotate-left:
  - `H0'=rotl(x3,1)+x0`
  - `H1'=rotl(x0,2)^x1`
  - `H2'=rotl(x1,3)+x2`
  - `H3'=rotl(x2,5)^x3^r`
- The round applied at `cnt=4*ROUNDS-1` is the last. At that edge:
  - `d[j]` is loaded with the finalized value (see Configuration);
  - `done` is set to 1;
  - the state returns to IDLE.
- `done` is cleared on the following edge.
- `start` is ignored while in RUN; no queuing.
- `d` keeps its value across IDLE and RUN until overwritten by the next completion.

## Timing
- Reset (async assert) forces:
  - `d[0..3]=8'h00`, `done=0`, state IDLE, `H` and `cnt` cleared.
- Reset release: the first edge with `rst_n=1` may capture `start`.
- Latency: capture at edge E0 → rounds at E1..E(4·ROUNDS). `done` and new `d` are visible after E(4·ROUNDS), which is E32 for the default ROUNDS.
- `done` is high for exactly one cycle per accepted `start`.
- Back-to-back operation:
  - `start` is accepted in the cycle where `done`=1, since the state is already IDLE;
  - that gives throughput of one hash per 4·ROUNDS+1 cycles.
- `start` held high continuously: a new hash begins on each IDLE edge.
- Reset mid-RUN: the operation is aborted, `done` is never raised, and `d` returns to 0.
- Results depend only on the values captured at E0.

## Configuration
- Macro `HASH_FEEDFORWARD_EN`:
  - Defined: `d[j]=H[j]^IV_lat[j]`. This is the Davies-Meyer style feed-forward.
  - Undefined: `d[j]=H[j]`, the raw final state.
- Timing and interface are identical in both builds.
- The bench reference model must follow the same macro.

## Test plan
- Reset: hold `rst_n`=0 → `d`=00 00 00 00 and `done`=0. Assert reset asynchronously mid-cycle → outputs clear immediately.
- Nominal hash:
  - stimulus: `m`=01 02 03 04, `IV`=34 55 0F 14, 1-cycle `start`;
  - required: `done` pulses exactly 32 edges after capture, for one cycle;
  - required: `d` equals the reference model output and still holds one edge after `done`.
- Second vector:
  - stimulus: `m`=FF EE DD CC, same IV;
  - required: `d` matches the model and differs from the first digest;
  - required: repeating the first vector reproduces the first digest exactly.
- `start` pulses during RUN, for example at cycles 5 and 20 → ignored: a single `done` at cycle 32 and a digest unchanged from the nominal case.
- Back-to-back: assert `start` in the `done` cycle → second `done` 33 cycles after the first. Changing `m` after capture does not alter the digest.
- Reset mid-RUN at cycle 10 → no `done` and `d`=0. A fresh `start` afterward gives the nominal digest. Repeat the run with `HASH_FEEDFORWARD_EN` undefined and check against the model for that build.
